// File: rtl/health_controller_pkg.sv
// Shared definitions for the fighter health controller: FSM states, winner codes,
// field widths and the saturating damage helper.
package health_controller_pkg;

  localparam int unsigned HealthW = 9;
  localparam int unsigned DmgW    = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StFight  = 2'b01,
    StKoWait = 2'b10,
    StKo     = 2'b11
  } state_e;

  localparam logic [1:0] WinNone  = 2'b00;
  localparam logic [1:0] WinLeft  = 2'b01;
  localparam logic [1:0] WinRight = 2'b10;
  localparam logic [1:0] WinDraw  = 2'b11;

  // Health minus damage, clamped at zero; damage is zero-extended to health width.
  function automatic logic [HealthW-1:0] sat_sub(input logic [HealthW-1:0] health,
                                                 input logic [DmgW-1:0]    dmg);
    logic [HealthW-1:0] dmg_ext;
    dmg_ext = {{(HealthW - DmgW){1'b0}}, dmg};
    return (health > dmg_ext) ? (health - dmg_ext) : '0;
  endfunction

endpackage

// File: rtl/health_controller_if.sv
// Bundle of combat-logic inputs, status-bar feedback and game-FSM outputs.
interface health_controller_if;
  import health_controller_pkg::*;

  logic               round_start;
  logic               hit_l;
  logic [DmgW-1:0]    dmg_l;
  logic               hit_r;
  logic [DmgW-1:0]    dmg_r;
  logic [HealthW-1:0] final_health_l;
  logic [HealthW-1:0] final_health_r;
  logic [HealthW-1:0] curr_health_l;
  logic [HealthW-1:0] curr_health_r;
  logic               hit_taken_l;
  logic               hit_taken_r;
  logic               round_active;
  logic               ko;
  logic [1:0]         winner;

  // Driver side (combat logic / status bar / game FSM).
  modport master (
    output round_start, hit_l, dmg_l, hit_r, dmg_r, final_health_l, final_health_r,
    input  curr_health_l, curr_health_r, hit_taken_l, hit_taken_r, round_active, ko, winner
  );

  // Health controller side.
  modport slave (
    input  round_start, hit_l, dmg_l, hit_r, dmg_r, final_health_l, final_health_r,
    output curr_health_l, curr_health_r, hit_taken_l, hit_taken_r, round_active, ko, winner
  );
endinterface

// File: rtl/health_controller_invuln_timer.sv
// Per-side post-hit invulnerability: decides whether a hit is accepted and, when it is,
// blocks further hits for INVULN_CYCLES clock cycles.
module health_controller_invuln_timer #(
  parameter int unsigned INVULN_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,   // new round: drop any pending invulnerability
  input  logic enable,  // hits only count while fighting
  input  logic hit,
  output logic accept
);

  logic [31:0] cnt_q;

  // A hit lands only when enabled and the side is not invulnerable.
  always_comb begin
    accept = enable && hit && (cnt_q == 32'd0);
  end

  // Load on an accepted hit, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (clear) begin
      cnt_q <= 32'd0;
    end else if (accept) begin
      cnt_q <= 32'(INVULN_CYCLES);
    end else if (cnt_q != 32'd0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

endmodule

// File: rtl/health_controller.sv
// Fighter health controller: applies damage, tracks the round FSM, latches the winner
// and holds KO until the status bar drain animation reaches zero (or times out).
module health_controller
  import health_controller_pkg::*;
#(
  parameter logic [HealthW-1:0] MAX_HEALTH    = 9'd100,
  parameter int unsigned        INVULN_CYCLES = 25_000_000,
  parameter int unsigned        KO_TIMEOUT    = 300_000_000
) (
  input logic               clk,
  input logic               rst_n,
  health_controller_if.slave bus
);

  state_e             state_q;
  logic [HealthW-1:0] health_l_q, health_r_q;
  logic [HealthW-1:0] health_l_d, health_r_d;
  logic               hit_taken_l_q, hit_taken_r_q;
  logic               round_active_q, ko_q;
  logic [1:0]         winner_q;
  logic [31:0]        ko_cnt_q;

  logic accept_l, accept_r;
  logic new_round, in_fight, ko_done, ko_timeout;

  always_comb begin
    new_round = bus.round_start && ((state_q == StIdle) || (state_q == StKo));
    in_fight  = (state_q == StFight);
  end

  health_controller_invuln_timer #(
    .INVULN_CYCLES(INVULN_CYCLES)
  ) u_invuln_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (new_round),
    .enable(in_fight),
    .hit   (bus.hit_l),
    .accept(accept_l)
  );

  health_controller_invuln_timer #(
    .INVULN_CYCLES(INVULN_CYCLES)
  ) u_invuln_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (new_round),
    .enable(in_fight),
    .hit   (bus.hit_r),
    .accept(accept_r)
  );

  // Post-hit health and KO release conditions.
  always_comb begin
    health_l_d = accept_l ? sat_sub(health_l_q, bus.dmg_l) : health_l_q;
    health_r_d = accept_r ? sat_sub(health_r_q, bus.dmg_r) : health_r_q;
    // Only a side that was knocked out has to wait for its bar to drain.
    ko_done    = ((health_l_q != '0) || (bus.final_health_l == '0)) &&
                 ((health_r_q != '0) || (bus.final_health_r == '0));
    ko_timeout = (ko_cnt_q == 32'(KO_TIMEOUT - 1));
  end

  // Round FSM with registered outputs, health registers and winner latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      health_l_q     <= MAX_HEALTH;
      health_r_q     <= MAX_HEALTH;
      hit_taken_l_q  <= 1'b0;
      hit_taken_r_q  <= 1'b0;
      round_active_q <= 1'b0;
      ko_q           <= 1'b0;
      winner_q       <= WinNone;
      ko_cnt_q       <= 32'd0;
    end else begin
      hit_taken_l_q <= 1'b0;
      hit_taken_r_q <= 1'b0;
      unique case (state_q)
        StIdle, StKo: begin
          if (bus.round_start) begin
            state_q        <= StFight;
            health_l_q     <= MAX_HEALTH;
            health_r_q     <= MAX_HEALTH;
            winner_q       <= WinNone;
            round_active_q <= 1'b1;
            ko_q           <= 1'b0;
          end
        end
        StFight: begin
          health_l_q    <= health_l_d;
          health_r_q    <= health_r_d;
          hit_taken_l_q <= accept_l;
          hit_taken_r_q <= accept_r;
          if ((health_l_d == '0) || (health_r_d == '0)) begin
            state_q        <= StKoWait;
            round_active_q <= 1'b0;
            ko_cnt_q       <= 32'd0;
            // Bit 1 set when left is down (right wins), bit 0 when right is down.
            winner_q       <= {health_l_d == '0, health_r_d == '0};
          end
        end
        StKoWait: begin
          if (ko_done || ko_timeout) begin
            state_q <= StKo;
            ko_q    <= 1'b1;
          end else begin
            ko_cnt_q <= ko_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.curr_health_l = health_l_q;
  assign bus.curr_health_r = health_r_q;
  assign bus.hit_taken_l   = hit_taken_l_q;
  assign bus.hit_taken_r   = hit_taken_r_q;
  assign bus.round_active  = round_active_q;
  assign bus.ko            = ko_q;
  assign bus.winner        = winner_q;

endmodule
